clock_ctrl: RTL and testbench

CLOCK_CTRL -- requirements
Module: clock_ctrl

---
 rtl/clock_ctrl.sv | 138 +++++++++++++
 tb/tb_clock_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// Alarm-clock controller: time/alarm edit FSM driving an external time counter,
// plus alarm matching with auto-off duration and snooze.
module clock_ctrl #(
   parameter int unsigned SNOOZE_MIN = 5,
   parameter int unsigned ALARM_SEC  = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode_btn,
   input  logic       inc_btn,
   input  logic       snooze_btn,
   input  logic       alarm_en,
   input  logic       sec_tick,
   input  logic [5:0] sec_in,
   input  logic [5:0] min_in,
   input  logic [4:0] hrs_in,
   output logic       hold,
   output logic       load,
   output logic [5:0] load_min,
   output logic [4:0] load_hrs,
   output logic       alarm,
   output logic [2:0] mode
);

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      SET_HRS  = 3'd1,
      SET_MIN  = 3'd2,
      SET_AHRS = 3'd3,
      SET_AMIN = 3'd4
   } state_t;

   state_t     state, state_n;
   logic [4:0] edit_hrs, al_hrs, snz_hrs;
   logic [5:0] edit_min, al_min, snz_min;
   logic       snz_pend;
   logic [7:0] dur_cnt;
   logic       inc_act;
   logic [4:0] tgt_hrs, snz_hrs_n;
   logic [5:0] tgt_min, snz_min_n;
   logic [6:0] snz_sum;
   logic       match;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (mode_btn) begin
         case (state)
            RUN:      state_n = SET_HRS;
            SET_HRS:  state_n = SET_MIN;
            SET_MIN:  state_n = SET_AHRS;
            SET_AHRS: state_n = SET_AMIN;
            SET_AMIN: state_n = RUN;
            default:  state_n = RUN;
         endcase
      end
   end

   assign hold     = (state == SET_HRS) || (state == SET_MIN);
   assign mode     = state;
   assign load_hrs = edit_hrs;
   assign load_min = edit_min;
   // A mode press in the same cycle takes priority over the increment.
   assign inc_act  = inc_btn && !mode_btn;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edit_hrs <= '0;
         edit_min <= '0;
         al_hrs   <= '0;
         al_min   <= '0;
         load     <= 1'b0;
      end else begin
         load <= (state == SET_MIN) && mode_btn;
         if ((state == RUN) && mode_btn) begin
            edit_hrs <= hrs_in;
            edit_min <= min_in;
         end
         if (inc_act) begin
            case (state)
               SET_HRS:  edit_hrs <= (edit_hrs == 5'd23) ? '0 : edit_hrs + 5'd1;
               SET_MIN:  edit_min <= (edit_min == 6'd59) ? '0 : edit_min + 6'd1;
               SET_AHRS: al_hrs   <= (al_hrs   == 5'd23) ? '0 : al_hrs   + 5'd1;
               SET_AMIN: al_min   <= (al_min   == 6'd59) ? '0 : al_min   + 6'd1;
               default: ;
            endcase
         end
      end
   end

   // Snooze target: current time plus SNOOZE_MIN, minute overflow carries into hours.
   assign snz_sum   = {1'b0, min_in} + 7'(SNOOZE_MIN);
   assign snz_min_n = (snz_sum >= 7'd60) ? 6'(snz_sum - 7'd60) : snz_sum[5:0];
   assign snz_hrs_n = (snz_sum < 7'd60) ? hrs_in :
                      (hrs_in == 5'd23) ? '0 : hrs_in + 5'd1;

   assign tgt_hrs = snz_pend ? snz_hrs : al_hrs;
   assign tgt_min = snz_pend ? snz_min : al_min;
   assign match   = alarm_en && !hold && sec_tick && (sec_in == 6'd0) &&
                    (hrs_in == tgt_hrs) && (min_in == tgt_min);

   // Priority: disable, then snooze (wins over a coincident match), then match, then countdown.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alarm    <= 1'b0;
         snz_pend <= 1'b0;
         snz_hrs  <= '0;
         snz_min  <= '0;
         dur_cnt  <= '0;
      end else if (!alarm_en) begin
         alarm    <= 1'b0;
         snz_pend <= 1'b0;
         dur_cnt  <= '0;
      end else if (alarm && snooze_btn) begin
         alarm    <= 1'b0;
         snz_pend <= 1'b1;
         snz_hrs  <= snz_hrs_n;
         snz_min  <= snz_min_n;
         dur_cnt  <= '0;
      end else if (match) begin
         alarm    <= 1'b1;
         snz_pend <= 1'b0;
         dur_cnt  <= 8'(ALARM_SEC);
      end else if (alarm && sec_tick && !hold) begin
         if (dur_cnt <= 8'd1) begin
            dur_cnt <= '0;
            alarm   <= 1'b0;
         end else begin
            dur_cnt <= dur_cnt - 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: vector table, directed corner sequences,
// and randomized traffic compared against a minutes-of-day reference model.
module tb_clock_ctrl;

   localparam int SNZ = 5;
   localparam int ASEC = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       mode_btn = 1'b0, inc_btn = 1'b0, snooze_btn = 1'b0;
   logic       alarm_en = 1'b0, sec_tick = 1'b0;
   logic [5:0] sec_in = '0, min_in = '0;
   logic [4:0] hrs_in = '0;
   logic       hold, load, alarm;
   logic [5:0] load_min;
   logic [4:0] load_hrs;
   logic [2:0] mode;

   clock_ctrl #(.SNOOZE_MIN(SNZ), .ALARM_SEC(ASEC)) dut (
      .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn),
      .snooze_btn(snooze_btn), .alarm_en(alarm_en), .sec_tick(sec_tick),
      .sec_in(sec_in), .min_in(min_in), .hrs_in(hrs_in), .hold(hold),
      .load(load), .load_min(load_min), .load_hrs(load_hrs), .alarm(alarm),
      .mode(mode)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // reference model state
   int m_mode, m_eh, m_em, m_ah, m_am, m_dur, m_snz;
   bit m_load, m_alarm, m_pend;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_mode = 0; m_eh = 0; m_em = 0; m_ah = 0; m_am = 0;
      m_dur = 0; m_snz = 0; m_load = 0; m_alarm = 0; m_pend = 0;
   endfunction

   function automatic void model_update(bit mb, bit ib, bit sb, bit en, bit st,
                                        int h, int m, int s);
      bit hld, mt;
      int now, tgt;
      hld = (m_mode == 1) || (m_mode == 2);
      now = h * 60 + m;
      tgt = m_pend ? m_snz : (m_ah * 60 + m_am);
      mt  = en && !hld && st && (s == 0) && (now == tgt);
      if (!en) begin
         m_alarm = 0; m_pend = 0; m_dur = 0;
      end else if (m_alarm && sb) begin
         m_alarm = 0; m_pend = 1; m_snz = (now + SNZ) % 1440; m_dur = 0;
      end else if (mt) begin
         m_alarm = 1; m_pend = 0; m_dur = ASEC;
      end else if (m_alarm && st && !hld) begin
         m_dur = m_dur - 1;
         if (m_dur <= 0) begin m_dur = 0; m_alarm = 0; end
      end
      m_load = (m_mode == 2) && mb;
      if (mb) begin
         if (m_mode == 0) begin m_eh = h; m_em = m; end
         m_mode = (m_mode + 1) % 5;
      end else if (ib) begin
         if (m_mode == 1) m_eh = (m_eh + 1) % 24;
         if (m_mode == 2) m_em = (m_em + 1) % 60;
         if (m_mode == 3) m_ah = (m_ah + 1) % 24;
         if (m_mode == 4) m_am = (m_am + 1) % 60;
      end
   endfunction

   task automatic cmp_all();
      chk("mode", int'(mode), m_mode);
      chk("hold", int'(hold), int'((m_mode == 1) || (m_mode == 2)));
      chk("load", int'(load), int'(m_load));
      chk("load_hrs", int'(load_hrs), m_eh);
      chk("load_min", int'(load_min), m_em);
      chk("alarm", int'(alarm), int'(m_alarm));
   endtask

   task automatic tick(input bit mb, input bit ib, input bit sb, input bit en,
                       input bit st, input int h, input int m, input int s);
      mode_btn = mb; inc_btn = ib; snooze_btn = sb; alarm_en = en; sec_tick = st;
      hrs_in = 5'(h); min_in = 6'(m); sec_in = 6'(s);
      @(posedge clk);
      #1;
      model_update(mb, ib, sb, en, st, h, m, s);
      cmp_all();
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      model_reset();
      cmp_all();
      chk("rst_mode", int'(mode), 0);
      chk("rst_hold", int'(hold), 0);
      chk("rst_load", int'(load), 0);
      chk("rst_alarm", int'(alarm), 0);
      @(posedge clk);
      #1;
      cmp_all();
      mode_btn = 1'b0; inc_btn = 1'b0; snooze_btn = 1'b0; sec_tick = 1'b0;
      reset = 1'b0;
   endtask

   typedef struct {
      bit mb; bit ib; int rep;
      int e_mode; bit e_hold; bit e_load; int e_lh; int e_lm;
   } vec_t;

   vec_t tbl[11];

   initial begin
      // set time 10:20 -> 13:05, then alarm target 07:30
      tbl[0]  = '{1, 0, 1,  1, 1, 0, 10, 20};
      tbl[1]  = '{0, 1, 3,  1, 1, 0, 13, 20};
      tbl[2]  = '{1, 0, 1,  2, 1, 0, 13, 20};
      tbl[3]  = '{0, 1, 45, 2, 1, 0, 13, 5};
      tbl[4]  = '{1, 0, 1,  3, 0, 1, 13, 5};
      tbl[5]  = '{0, 0, 1,  3, 0, 0, 13, 5};
      tbl[6]  = '{0, 1, 7,  3, 0, 0, 13, 5};
      tbl[7]  = '{1, 0, 1,  4, 0, 0, 13, 5};
      tbl[8]  = '{0, 1, 30, 4, 0, 0, 13, 5};
      tbl[9]  = '{1, 0, 1,  0, 0, 0, 13, 5};
      tbl[10] = '{0, 0, 2,  0, 0, 0, 13, 5};

      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      for (int i = 0; i < 11; i++) begin
         for (int r = 0; r < tbl[i].rep; r++)
            tick(tbl[i].mb, tbl[i].ib, 0, 1, 0, 10, 20, 30);
         chk($sformatf("tbl%0d_mode", i), int'(mode), tbl[i].e_mode);
         chk($sformatf("tbl%0d_hold", i), int'(hold), int'(tbl[i].e_hold));
         chk($sformatf("tbl%0d_load", i), int'(load), int'(tbl[i].e_load));
         chk($sformatf("tbl%0d_lh", i), int'(load_hrs), tbl[i].e_lh);
         chk($sformatf("tbl%0d_lm", i), int'(load_min), tbl[i].e_lm);
      end

      // alarm fires at 07:30:00 and auto-clears after ASEC further ticks
      tick(0, 0, 0, 1, 1, 7, 30, 0);  chk("alarm_on", int'(alarm), 1);
      tick(0, 0, 0, 1, 1, 7, 30, 1);  chk("alarm_t1", int'(alarm), 1);
      tick(0, 0, 0, 1, 1, 7, 30, 2);  chk("alarm_t2", int'(alarm), 1);
      tick(0, 0, 0, 1, 1, 7, 30, 3);  chk("alarm_off", int'(alarm), 0);

      // hours wrap and simultaneous buttons
      tick(1, 0, 0, 1, 0, 23, 15, 10); chk("cap_hrs", int'(load_hrs), 23);
      tick(0, 1, 0, 1, 0, 23, 15, 11); chk("wrap_hrs", int'(load_hrs), 0);
      chk("wrap_min", int'(load_min), 15);
      tick(1, 1, 0, 1, 0, 23, 15, 12); chk("both_mode", int'(mode), 2);
      chk("both_hrs", int'(load_hrs), 0);
      tick(1, 0, 0, 1, 0, 23, 15, 13); chk("load2", int'(load), 1);
      tick(1, 0, 0, 1, 0, 23, 15, 14);
      for (int k = 0; k < 28; k++) tick(0, 1, 0, 1, 0, 23, 15, 15);
      tick(1, 0, 0, 1, 0, 23, 15, 16); chk("back_run", int'(mode), 0);

      // snooze across the hour: 07:58 -> 08:03
      tick(0, 0, 0, 1, 1, 7, 58, 0);  chk("alarm_0758", int'(alarm), 1);
      tick(0, 0, 1, 1, 0, 7, 58, 10); chk("snooze_clr", int'(alarm), 0);
      tick(0, 0, 0, 1, 1, 7, 58, 0);  chk("pend_0758", int'(alarm), 0);
      tick(0, 0, 0, 1, 1, 8, 2, 0);   chk("pend_0802", int'(alarm), 0);
      tick(0, 0, 0, 1, 1, 8, 3, 0);   chk("snooze_fire", int'(alarm), 1);
      tick(0, 0, 0, 0, 0, 8, 3, 1);   chk("disable", int'(alarm), 0);

      // reset in the middle of an edit abandons it
      tick(1, 0, 0, 1, 0, 9, 9, 9);
      tick(1, 0, 0, 1, 0, 9, 9, 9);   chk("in_setmin", int'(mode), 2);
      do_reset();
      for (int k = 0; k < 4; k++) begin
         tick(0, 0, 0, 1, 0, 9, 9, 9);
         chk("no_load", int'(load), 0);
      end

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         bit mb, ib, sb, en, st;
         int h, m, s, sel;
         mb  = ($urandom_range(0, 7) == 0);
         ib  = ($urandom_range(0, 2) == 0);
         sb  = ($urandom_range(0, 9) == 0);
         en  = ($urandom_range(0, 15) != 0);
         st  = ($urandom_range(0, 1) == 0);
         sel = $urandom_range(0, 3);
         if (sel == 0) begin h = m_ah; m = m_am; end
         else if (sel == 1) begin h = m_snz / 60; m = m_snz % 60; end
         else begin h = $urandom_range(0, 23); m = $urandom_range(0, 59); end
         s = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 59);
         tick(mb, ib, sb, en, st, h, m, s);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
